// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed hex display scanner with a double-buffered digit register.
// Writes land in a shadow copy that is committed to the displayed copy once per frame.
module display_scan_ctrl #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Wr,
    input  logic [1:0]  i_Addr,
    input  logic [3:0]  i_Data,
    input  logic        i_Wr_All,
    input  logic [15:0] i_Word,
    input  logic [3:0]  i_Mask,
    input  logic        i_Lz,
    output logic [3:0]  o_Anodo,
    output logic [1:0]  o_Sel,
    output logic [6:0]  o_Seg,
    output logic        o_Frame
);

    typedef enum logic {
        DRIVE = 1'b0,
        BLANK = 1'b1
    } state_t;

    localparam logic [15:0] LAST_CNT    = 16'(CLK_DIV - 1);
    localparam logic [15:0] BLANK_START = 16'(CLK_DIV - BLANK_CYCLES);
    localparam logic [6:0]  SEG_OFF     = 7'b1111111;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] active_q, active_d;
    logic [3:0]  anodo_q, anodo_d;
    logic [6:0]  seg_q, seg_d;
    logic        frame_q, frame_d;
    logic        wrap;
    logic        commit;
    logic        suppress;
    logic [3:0]  digit;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Next slot position; the output registers are loaded from this position so
    // anode, select and segments always describe the same cycle.
    always_comb begin
        wrap   = (cnt_q == LAST_CNT);
        cnt_d  = wrap ? 16'd0 : cnt_q + 16'd1;
        sel_d  = wrap ? sel_q + 2'd1 : sel_q;
        commit = wrap && (sel_q == 2'd3);

        state_d = state_q;
        case (state_q)
            DRIVE: if ((BLANK_CYCLES != 0) && (cnt_d == BLANK_START)) state_d = BLANK;
            BLANK: if (wrap) state_d = DRIVE;
            default: state_d = DRIVE;
        endcase
    end

    // The commit reads shadow_q, so a write in the commit cycle waits for the next frame.
    always_comb begin
        active_d = commit ? shadow_q : active_q;
        shadow_d = shadow_q;
        if (i_Wr_All) begin
            shadow_d = i_Word;
        end else if (i_Wr) begin
            shadow_d[i_Addr*4 +: 4] = i_Data;
        end
    end

    always_comb begin
        digit = active_d[sel_d*4 +: 4];
        case (sel_d)
            2'd1:    suppress = i_Lz && (active_d[15:4] == 12'h000);
            2'd2:    suppress = i_Lz && (active_d[15:8] == 8'h00);
            2'd3:    suppress = i_Lz && (active_d[15:12] == 4'h0);
            default: suppress = 1'b0;
        endcase

        anodo_d = 4'b1111;
        seg_d   = SEG_OFF;
        if (state_d == DRIVE) begin
            if (i_Mask[sel_d]) anodo_d = 4'b1111 ^ (4'b0001 << sel_d);
            seg_d = suppress ? SEG_OFF : glyph(digit);
        end
        frame_d = commit;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= DRIVE;
            cnt_q    <= 16'd0;
            sel_q    <= 2'd0;
            shadow_q <= 16'h0000;
            active_q <= 16'h0000;
            anodo_q  <= 4'b1110;
            seg_q    <= 7'b1000000;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            anodo_q  <= anodo_d;
            seg_q    <= seg_d;
            frame_q  <= frame_d;
        end
    end

    assign o_Anodo = anodo_q;
    assign o_Sel   = sel_q;
    assign o_Seg   = seg_q;
    assign o_Frame = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl at CLK_DIV=8, BLANK_CYCLES=2.
// pos counts cycles since the last reset edge: digit = pos/8 mod 4, slot cycle = pos mod 8.
module tb_display_scan_ctrl;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b1;
    logic        i_Wr = 1'b0;
    logic [1:0]  i_Addr = 2'd0;
    logic [3:0]  i_Data = 4'd0;
    logic        i_Wr_All = 1'b0;
    logic [15:0] i_Word = 16'h0000;
    logic [3:0]  i_Mask = 4'b1111;
    logic        i_Lz = 1'b0;
    logic [3:0]  o_Anodo;
    logic [1:0]  o_Sel;
    logic [6:0]  o_Seg;
    logic        o_Frame;

    int vectors = 0;
    int errors  = 0;
    int pos     = 0;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GF = 7'b0001110;
    localparam logic [6:0] OFF = 7'b1111111;

    display_scan_ctrl #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Wr(i_Wr), .i_Addr(i_Addr), .i_Data(i_Data),
        .i_Wr_All(i_Wr_All), .i_Word(i_Word), .i_Mask(i_Mask), .i_Lz(i_Lz),
        .o_Anodo(o_Anodo), .o_Sel(o_Sel), .o_Seg(o_Seg), .o_Frame(o_Frame)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic tick();
        @(posedge i_Clk);
        #1;
        pos++;
    endtask

    task automatic go_to(input int p);
        while (pos < p) tick();
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s at pos %0d: observed %h expected %h", tag, pos, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an, input logic [1:0] sel,
                           input logic [6:0] seg, input logic fr);
        chk({tag, "_anodo"}, {12'h0, o_Anodo}, {12'h0, an});
        chk({tag, "_sel"},   {14'h0, o_Sel},   {14'h0, sel});
        chk({tag, "_seg"},   {9'h0, o_Seg},    {9'h0, seg});
        chk({tag, "_frame"}, {15'h0, o_Frame}, {15'h0, fr});
    endtask

    initial begin
        logic [3:0] exp_an;
        // Reset and scan timing
        i_Rst = 1'b1;
        tick();
        tick();
        pos = 0;
        chk_out("reset", 4'b1110, 2'd0, G0, 1'b0);
        i_Rst = 1'b0;
        for (int p = 0; p <= 40; p++) begin
            go_to(p);
            exp_an = ((p % 8) < 6) ? (4'b1111 ^ (4'b0001 << ((p / 8) % 4))) : 4'b1111;
            chk("scan_anodo", {12'h0, o_Anodo}, {12'h0, exp_an});
            chk("scan_sel", {14'h0, o_Sel}, {14'h0, 2'((p / 8) % 4)});
            chk("scan_frame", {15'h0, o_Frame}, {15'h0, (p == 32)});
        end

        // Whole-word write during digit 1 waits for the frame boundary
        i_Wr_All = 1'b1; i_Word = 16'h12AF;
        tick();
        i_Wr_All = 1'b0;
        go_to(56); chk_out("wall_old_d3", 4'b0111, 2'd3, G0, 1'b0);
        go_to(64); chk_out("wall_d0", 4'b1110, 2'd0, GF, 1'b1);
        go_to(65); chk_out("wall_d0_c1", 4'b1110, 2'd0, GF, 1'b0);
        go_to(70); chk_out("wall_blank", 4'b1111, 2'd0, OFF, 1'b0);
        go_to(72); chk_out("wall_d1", 4'b1101, 2'd1, GA, 1'b0);
        go_to(80); chk_out("wall_d2", 4'b1011, 2'd2, G2, 1'b0);
        go_to(88); chk_out("wall_d3", 4'b0111, 2'd3, G1, 1'b0);

        // Single-digit write in the commit cycle shows one frame later
        go_to(95);
        i_Wr = 1'b1; i_Addr = 2'd2; i_Data = 4'h5;
        tick();
        i_Wr = 1'b0;
        chk_out("wr_commit_d0", 4'b1110, 2'd0, GF, 1'b1);
        go_to(112); chk_out("wr_old_d2", 4'b1011, 2'd2, G2, 1'b0);
        go_to(128); chk_out("wr_next_frame", 4'b1110, 2'd0, GF, 1'b1);
        go_to(144); chk_out("wr_new_d2", 4'b1011, 2'd2, G5, 1'b0);

        // Whole-word write wins over a same-cycle digit write
        go_to(150);
        i_Wr = 1'b1; i_Addr = 2'd0; i_Data = 4'h7;
        i_Wr_All = 1'b1; i_Word = 16'h0000;
        tick();
        i_Wr = 1'b0; i_Wr_All = 1'b0;
        go_to(160); chk_out("prio_d0", 4'b1110, 2'd0, G0, 1'b1);
        go_to(168); chk_out("prio_d1", 4'b1101, 2'd1, G0, 1'b0);
        go_to(176); chk_out("prio_d2", 4'b1011, 2'd2, G0, 1'b0);
        go_to(184); chk_out("prio_d3", 4'b0111, 2'd3, G0, 1'b0);

        // Leading-zero suppression on 0x0040, then digit-0 mask
        go_to(190);
        i_Wr_All = 1'b1; i_Word = 16'h0040; i_Lz = 1'b1;
        tick();
        i_Wr_All = 1'b0;
        go_to(192); chk_out("lz_d0", 4'b1110, 2'd0, G0, 1'b1);
        go_to(200); chk_out("lz_d1", 4'b1101, 2'd1, G4, 1'b0);
        go_to(208); chk_out("lz_d2", 4'b1011, 2'd2, OFF, 1'b0);
        go_to(216); chk_out("lz_d3", 4'b0111, 2'd3, OFF, 1'b0);
        go_to(220);
        i_Mask = 4'b1110;
        for (int p = 224; p < 232; p++) begin
            go_to(p);
            chk("mask_d0_anodo", {12'h0, o_Anodo}, 16'h000F);
        end
        go_to(232); chk_out("mask_d1", 4'b1101, 2'd1, G4, 1'b0);
        i_Mask = 4'b1111; i_Lz = 1'b0;
        go_to(240); chk_out("nolz_d2", 4'b1011, 2'd2, G0, 1'b0);

        // Reset during digit-2 blanking overrides a same-cycle write
        go_to(278);
        chk_out("pre_rst_blank", 4'b1111, 2'd2, OFF, 1'b0);
        i_Rst = 1'b1; i_Wr_All = 1'b1; i_Word = 16'hFFFF;
        tick();
        i_Rst = 1'b0; i_Wr_All = 1'b0;
        pos = 0;
        chk_out("rst_mid", 4'b1110, 2'd0, G0, 1'b0);
        go_to(6);  chk_out("rst_blank0", 4'b1111, 2'd0, OFF, 1'b0);
        go_to(8);  chk_out("rst_active_d1", 4'b1101, 2'd1, G0, 1'b0);
        go_to(32); chk_out("rst_commit", 4'b1110, 2'd0, G0, 1'b1);
        go_to(40); chk_out("rst_shadow_d1", 4'b1101, 2'd1, G0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: observed no completion expected finish before 100000");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 50000: total clock cycles per digit slot; legal range 2..65535.
REQ-002 Parameter BLANK_CYCLES, default 500: anode-off dead time at the end of each slot; legal range 0..CLK_DIV-1.
REQ-003 i_Clk  in  1  the only clock; all state changes on its rising edge.
REQ-004 i_Rst  in  1  synchronous, active-high reset.
REQ-005 i_Wr  in  1  single-digit write strobe into the shadow register.
REQ-006 i_Addr  in  2  digit index for i_Wr (0 = rightmost digit).
REQ-007 i_Data  in  4  hex value for i_Wr.
REQ-008 i_Wr_All  in  1  whole-word write strobe into the shadow register.
REQ-009 i_Word  in  16  four digits for i_Wr_All; [3:0] is digit 0 and [15:12] is digit 3.
REQ-010 i_Mask  in  4  per-digit enable (1 = digit lit).
REQ-011 i_Lz  in  1  leading-zero suppression enable.
REQ-012 o_Anodo  out  4  anode drive, active-low, one-hot-low or all ones.
REQ-013 o_Sel  out  2  index of the current slot.
REQ-014 o_Seg  out  7  segment drive, active-low, bit order gfedcba.
REQ-015 o_Frame  out  1  one-cycle pulse on shadow-to-active commit.

Function
REQ-016 A slot counter SHALL run 0..CLK_DIV-1; when it wraps, o_Sel SHALL advance 0->1->2->3->0.
REQ-017 During slot cycles 0..CLK_DIV-BLANK_CYCLES-1 (state DRIVE), o_Anodo SHALL drive the bit o_Sel low (0:1110, 1:1101, 2:1011, 3:0111).
REQ-018 During slot cycles CLK_DIV-BLANK_CYCLES..CLK_DIV-1 (state BLANK), o_Anodo SHALL be 4'b1111 and o_Seg SHALL be 7'b1111111.
REQ-019 When BLANK_CYCLES is 0, the BLANK state SHALL never be entered.
REQ-020 o_Anodo, o_Sel, o_Seg and o_Frame SHALL be registered outputs that update on the same edge, with no combinational path from inputs to outputs.
REQ-021 o_Seg SHALL show standard hex glyphs of the active digit: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110; the other values SHALL use the conventional b, C, d, E forms.
REQ-022 A digit with i_Mask bit 0 SHALL keep o_Anodo at 1111 for its whole slot; the slot time SHALL still be consumed.
REQ-023 With i_Lz=1, digit k (k=3,2,1) SHALL be blanked (o_Seg=1111111, anode still active) when active digits k..3 are all zero; digit 0 SHALL never be suppressed.
REQ-024 i_Wr SHALL write i_Data into shadow digit i_Addr; i_Wr_All SHALL write i_Word into all four shadow digits.
REQ-025 If i_Wr and i_Wr_All are asserted in the same cycle, i_Wr_All SHALL win and i_Wr SHALL be ignored.
REQ-026 On the edge where o_Sel goes from 3 to 0, the active register SHALL load the shadow register and o_Frame SHALL be 1 for exactly that first digit-0 cycle.
REQ-027 The commit SHALL use the shadow contents from before a same-cycle write; that write SHALL become visible at the next commit.
REQ-028 Displayed values SHALL therefore change only at frame boundaries, and write-to-display latency SHALL be at most 4*CLK_DIV+1 cycles.
REQ-029 i_Mask and i_Lz SHALL be sampled every cycle and take effect on the next output edge.

Reset
REQ-030 While i_Rst=1 at a rising edge, the block SHALL set o_Anodo=1110, o_Sel=00, o_Seg=1000000 and o_Frame=0.
REQ-031 The same reset edge SHALL clear the slot counter and state to DRIVE, and clear the shadow and active registers to 0x0000.
REQ-032 Reset SHALL override any write in the same cycle.
REQ-033 Reset asserted mid-slot or mid-frame SHALL abandon the slot; the first cycle after release SHALL be slot cycle 0 of digit 0.

Verification (CLK_DIV=8, BLANK_CYCLES=2, i_Mask=1111, i_Lz=0 unless stated)
REQ-034 Release reset -> o_Anodo=1110 for 6 cycles, then 1111 for 2, then 1101; o_Sel sequence 0,1,2,3,0 every 8 cycles.
REQ-035 i_Wr_All with 0x12AF during digit 1 -> no change until the 3->0 edge; then o_Frame=1 for 1 cycle and digits 0..3 show F,A,2,1 (0001110, 0001000, 0100100, 1111001).
REQ-036 i_Wr addr 2 data 5 in the same cycle as the 3->0 commit -> o_Frame pulses, digit 2 keeps its old value; it shows 5 (0010010) after the following commit.
REQ-037 Same-cycle i_Wr (addr 0, 7) and i_Wr_All (0x0000) -> after commit, all digits show 0.
REQ-038 Active 0x0040 with i_Lz=1 -> digits 3 and 2 have anode low with o_Seg=1111111; digit 1 shows 4 and digit 0 shows 0. With i_Mask=1110, digit 0 anode stays 1111 for its full slot.
REQ-039 Reset asserted during digit-2 BLANK -> next cycle outputs are 1110/00/1000000, and shadow and active read 0 after the next commit.
